// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the RV32I instruction assembler.
// Holds the format selectors, the NOP substitute, the opcode constants and the
// staged request record with its field-packing helper.
package instruction_assembler_pkg;

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] B_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Request fields captured in S1 (funct7 is never encoded, so not kept).
  typedef struct packed {
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

  // Scatter the immediate into its format-specific bit positions.
  function automatic logic [31:0] pack_instruction(input fields_t f);
    logic [31:0] w;
    w = NOP_INSTRUCTION;
    case (f.itype)
      I_TYPE: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      S_TYPE: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      B_TYPE: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                   f.imm[4:1], f.imm[11], f.opcode};
      U_TYPE: w = {f.imm[31:12], f.rd, f.opcode};
      J_TYPE: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = NOP_INSTRUCTION;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instruction_assembler_if.sv
// Request/response bundle between the injection port and the assembler.
// slave: assembler side (takes request fields, drives the assembled word);
// master: injector/fetch side. Carries valid/ready on both ends plus counters.
interface instruction_assembler_if;
  import instruction_assembler_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  instruction_type;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        imm_error;
  logic [15:0] encoded_count;
  logic [7:0]  error_count;

  modport slave (
    input  in_valid, instruction_type, opcode, funct3, funct7, rd, rs1, rs2,
           immediate, out_ready,
    output in_ready, out_valid, instruction, imm_error, encoded_count, error_count
  );

  modport master (
    output in_valid, instruction_type, opcode, funct3, funct7, rd, rs1, rs2,
           immediate, out_ready,
    input  in_ready, out_valid, instruction, imm_error, encoded_count, error_count
  );

endinterface

// File: rtl/immediate_range_checker.sv
// Flags immediates that cannot be represented by the selected format.
// Purely combinational; no state, no handshake.
// Ports: instruction_type, immediate in; imm_error out (1 = unencodable).
module immediate_range_checker
  import instruction_assembler_pkg::*;
(
  input  logic [2:0]  instruction_type,
  input  logic [31:0] immediate,
  output logic        imm_error
);

  // Sign-extension fits iff all bits above the field's top bit equal it.
  logic fits12, fits13, fits21;

  always_comb begin
    fits12 = (&immediate[31:11]) || ~(|immediate[31:11]);
    fits13 = (&immediate[31:12]) || ~(|immediate[31:12]);
    fits21 = (&immediate[31:20]) || ~(|immediate[31:20]);
    imm_error = 1'b1;
    case (instruction_type)
      I_TYPE, S_TYPE: imm_error = !fits12;
      B_TYPE:         imm_error = !(fits13 && !immediate[0]);
      J_TYPE:         imm_error = !(fits21 && !immediate[0]);
      U_TYPE:         imm_error = |immediate[11:0];
      default:        imm_error = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_assembler.sv
// Two-stage RV32I encoder: S1 registers fields + range error, S2 the packed word.
// Latency 2 cycles, one word per cycle; in_ready is combinational from out_ready.
// Ports: clk, reset (sync, active-high), bus (slave modport of the request bundle).
module instruction_assembler
  import instruction_assembler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  instruction_assembler_if.slave bus
);

  logic        s1_valid_q, s1_valid_d;
  fields_t     s1_fields_q, s1_fields_d;
  logic        s1_err_q, s1_err_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instruction_q, instruction_d;
  logic        imm_error_q, imm_error_d;
  logic [15:0] encoded_count_q, encoded_count_d;
  logic [7:0]  error_count_q, error_count_d;

  logic s2_adv, s1_adv, out_fire, range_err;
  logic unused_funct7;

  // funct7 has no slot in any supported format.
  assign unused_funct7 = ^bus.funct7;

  immediate_range_checker u_range_checker (
    .instruction_type (bus.instruction_type),
    .immediate        (bus.immediate),
    .imm_error        (range_err)
  );

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_fire = out_valid_q && bus.out_ready;

  assign bus.in_ready      = s1_adv && !reset;
  assign bus.out_valid     = out_valid_q;
  assign bus.instruction   = instruction_q;
  assign bus.imm_error     = imm_error_q;
  assign bus.encoded_count = encoded_count_q;
  assign bus.error_count   = error_count_q;

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_fields_d     = s1_fields_q;
    s1_err_d        = s1_err_q;
    out_valid_d     = out_valid_q;
    instruction_d   = instruction_q;
    imm_error_d     = imm_error_q;
    encoded_count_d = encoded_count_q;
    error_count_d   = error_count_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_fields_d = '{itype:  bus.instruction_type, opcode: bus.opcode,
                        funct3: bus.funct3, rd: bus.rd, rs1: bus.rs1,
                        rs2:    bus.rs2, imm: bus.immediate};
        s1_err_d    = range_err;
      end
    end

    // Word and flag only change when a new S1 entry moves in, so a bubble
    // leaves the last word on the bus with out_valid low.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instruction_d = s1_err_q ? NOP_INSTRUCTION : pack_instruction(s1_fields_q);
        imm_error_d   = s1_err_q;
      end
    end

    if (out_fire) begin
      encoded_count_d = encoded_count_q + 16'd1;
      if (imm_error_q && (error_count_q != 8'hFF)) begin
        error_count_d = error_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q      <= 1'b0;
      s1_fields_q     <= '0;
      s1_err_q        <= 1'b0;
      out_valid_q     <= 1'b0;
      instruction_q   <= '0;
      imm_error_q     <= 1'b0;
      encoded_count_q <= '0;
      error_count_q   <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_fields_q     <= s1_fields_d;
      s1_err_q        <= s1_err_d;
      out_valid_q     <= out_valid_d;
      instruction_q   <= instruction_d;
      imm_error_q     <= imm_error_d;
      encoded_count_q <= encoded_count_d;
      error_count_q   <= error_count_d;
    end
  end

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: encodings, range errors,
// backpressure, mid-flight reset and error-counter saturation.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_instruction_assembler;
  import instruction_assembler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_enc = 0;
  int   exp_err = 0;

  instruction_assembler_if bus ();

  instruction_assembler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] t, input logic [6:0] opc,
                            input logic [2:0] f3, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    bus.instruction_type = t;
    bus.opcode           = opc;
    bus.funct3           = f3;
    bus.funct7           = 7'h5A;
    bus.rd               = rd;
    bus.rs1              = rs1;
    bus.rs2              = rs2;
    bus.immediate        = imm;
  endtask

  // One isolated word with out_ready held high.
  task automatic send(input string tag, input logic [2:0] t, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_flag);
    @(negedge clk);
    set_fields(t, opc, f3, rd, rs1, rs2, imm);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_valid_after_1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_after_2"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.instruction, exp_instr);
    check({tag, "_imm_error"}, 32'(bus.imm_error), 32'(exp_flag));
    @(negedge clk);
    exp_enc = exp_enc + 1;
    if (exp_flag && exp_err < 255) exp_err = exp_err + 1;
    check({tag, "_enc_cnt"}, 32'(bus.encoded_count), 32'(exp_enc));
    check({tag, "_err_cnt"}, 32'(bus.error_count), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_enc = 0;
    exp_err = 0;
  endtask

  logic [31:0] bp_words [4];

  initial begin
    bp_words[0] = 32'h00100093;  // addi x1, x0, 1
    bp_words[1] = 32'h00200113;  // addi x2, x0, 2
    bp_words[2] = 32'h00300193;  // addi x3, x0, 3
    bp_words[3] = 32'h00400213;  // addi x4, x0, 4

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_imm_error", 32'(bus.imm_error), 32'd0);
    check("rst_enc_cnt", 32'(bus.encoded_count), 32'd0);
    check("rst_err_cnt", 32'(bus.error_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;

    // Legal encodings
    send("i_addi", I_TYPE, OPC_OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    send("b_beq",  B_TYPE, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0);
    send("u_lui",  U_TYPE, OPC_LUI,    3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send("s_sw",   S_TYPE, OPC_STORE,  3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b0);
    send("j_jal",  J_TYPE, OPC_JAL,    3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
    send("i_min",  I_TYPE, OPC_OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000013, 1'b0);

    // Range, alignment and type violations
    send("j_odd",  J_TYPE, OPC_JAL,    3'd0, 5'd1, 5'd0, 5'd0, 32'd3,        NOP_INSTRUCTION, 1'b1);
    send("i_big",  I_TYPE, OPC_OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, NOP_INSTRUCTION, 1'b1);
    send("type6",  3'd6,   OPC_OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        NOP_INSTRUCTION, 1'b1);
    send("b_odd",  B_TYPE, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'd6 + 32'd1, NOP_INSTRUCTION, 1'b1);
    send("u_low",  U_TYPE, OPC_LUI,    3'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, NOP_INSTRUCTION, 1'b1);

    // Backpressure: four back-to-back words against a stalled consumer
    do_reset();
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    bus.in_valid = 1'b1;
    #1 check("bp_accept0", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    #1 check("bp_accept1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    #1 check("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
    check("bp_head_word", bus.instruction, bp_words[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      check("bp_stall_word", bus.instruction, bp_words[0]);
      check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd4, 5'd0, 5'd0, 32'd4);
    #1 check("bp_out1", bus.instruction, bp_words[1]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("bp_out2", bus.instruction, bp_words[2]);
    @(negedge clk);
    #1 check("bp_out3", bus.instruction, bp_words[3]);
    check("bp_out3_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    #1 check("bp_drained", 32'(bus.out_valid), 32'd0);
    check("bp_enc_cnt", 32'(bus.encoded_count), 32'd4);
    check("bp_err_cnt", 32'(bus.error_count), 32'd0);
    exp_enc = 4;

    // Reset with two words in flight
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    set_fields(I_TYPE, OPC_OP_IMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mr_pre_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1 check("mr_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_enc_cnt", 32'(bus.encoded_count), 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mr_flushed", 32'(bus.out_valid), 32'd0);
    exp_enc = 0;
    exp_err = 0;
    send("mr_new", U_TYPE, OPC_AUIPC, 3'd0, 5'd7, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF397, 1'b0);

    // Error counter saturation: 300 illegal-type words streamed at full rate
    @(negedge clk);
    set_fields(3'd7, OPC_OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (300) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_err_cnt", 32'(bus.error_count), 32'd255);
    check("sat_enc_cnt", 32'(bus.encoded_count), 32'd301);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
